// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_arbiter_pkg
// Purpose : Shared types and constants for the N-port memory arbiter.
//           - FSM state encoding for the arbiter top level
//           - Arbitration mode constants (fixed priority / round-robin)
//           - Width helpers so 1-requester and TIMEOUT=0 builds stay legal
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } type_mem_arb_nport_states_e;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   // Index width; a single requester still gets a 1-bit index pinned to 0.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Timeout counter width; a disabled timeout still gets a 1-bit counter.
   function automatic int cnt_width(input int tout);
      return (tout > 0) ? $clog2(tout + 1) : 1;
   endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational N-way picker.
//           mode_i = ARB_FIXED : lowest requesting index wins.
//           mode_i = ARB_RR    : first requester at or after ptr_i wins,
//                                wrapping N_REQ-1 -> 0.
// Ports   : req_i   in  N_REQ  request vector (already kill-masked)
//           ptr_i   in  IDX_W  round-robin start index
//           mode_i  in  1      arbitration mode
//           valid_o out 1      at least one request present
//           idx_o   out IDX_W  winning index (0 when valid_o is low)
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
   import mem_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic             mode_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      int   start;
      int   cand;
      logic found;
      found = 1'b0;
      idx_o = '0;
      // Fixed priority is simply round-robin with the scan anchored at 0.
      // The modulo keeps a stray pointer value legal for non power-of-two N.
      start = (mode_i == ARB_RR) ? (int'(ptr_i) % N_REQ) : 0;
      cand  = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (start + k) % N_REQ;
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = IDX_W'(cand);
         end
      end
      valid_o = found;
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_arbiter_nport.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_nport
// Purpose : N-requester arbiter in front of a single memory port.
//           Fixed-priority or round-robin grant, per-channel kill, uniform
//           timeout and a registered memory-side request that is held
//           constant for the whole transaction.
// Ports   : clk, rst_n          clock / asynchronous active-low reset
//           req_i[N]            per-channel request (held until done)
//           req_kill_i[N]       per-channel abort
//           req_w_en_i[N]       1 = write, 0 = read
//           req_addr_i          packed addresses, slice k = channel k
//           req_w_data_i        packed write data, slice k = channel k
//           req_ack_o[N]        one-cycle completion pulse (combinational)
//           req_r_data_o        shared read data, valid with the ack
//           req_tout_o[N]       one-cycle timeout pulse (registered)
//           mem_req_o, mem_w_en_o, mem_addr_o, mem_w_data_o  registered
//           mem_ack_i, mem_r_data_i   memory completion and read data
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter_nport
   import mem_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 128,
   parameter int ARB_MODE = 1,
   parameter int TIMEOUT  = 48
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ-1:0]         req_kill_i,
   input  logic [N_REQ-1:0]         req_w_en_i,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]  req_w_data_i,
   output logic [N_REQ-1:0]         req_ack_o,
   output logic [DATA_W-1:0]        req_r_data_o,
   output logic [N_REQ-1:0]         req_tout_o,
   output logic                     mem_req_o,
   output logic                     mem_w_en_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [DATA_W-1:0]        mem_w_data_o,
   input  logic                     mem_ack_i,
   input  logic [DATA_W-1:0]        mem_r_data_i
);

   localparam int               IDX_W    = idx_width(N_REQ);
   localparam int               CNT_W    = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic             MODE     = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   type_mem_arb_nport_states_e state_q;
   logic [IDX_W-1:0]           grant_q;
   logic [IDX_W-1:0]           ptr_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       mem_req_q;
   logic                       mem_w_en_q;
   logic [ADDR_W-1:0]          mem_addr_q;
   logic [DATA_W-1:0]          mem_w_data_q;
   logic [N_REQ-1:0]           tout_q;

   // Next-state values used by the FSM
   logic [IDX_W-1:0]           ptr_d;
   logic [CNT_W-1:0]           cnt_d;

   // ---------------------------------------------------------------------
   // Per-channel views of the packed request buses
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_slice  [N_REQ];
   logic [DATA_W-1:0] wdata_slice [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign addr_slice[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
      assign wdata_slice[k] = req_w_data_i[k*DATA_W +: DATA_W];
   end

   // ---------------------------------------------------------------------
   // Winner selection: a killed channel is never a candidate
   // ---------------------------------------------------------------------
   logic [N_REQ-1:0] req_eligible;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   assign req_eligible = req_i & ~req_kill_i;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req_eligible),
      .ptr_i   (ptr_q),
      .mode_i  (MODE),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Pointer moves just past the winner so the winner has lowest priority next.
   assign ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

   // Saturating increment: a stuck counter must never wrap back below CNT_LAST.
   assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // ---------------------------------------------------------------------
   // Decode of the granted channel
   // ---------------------------------------------------------------------
   logic [N_REQ-1:0] grant_onehot;
   logic             kill_grant;
   logic             cnt_done;
   logic             ack_fire;

   always_comb begin
      grant_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         grant_onehot[k] = (grant_q == IDX_W'(k));
      end
   end

   // Only the granted channel's kill matters once a transaction is running.
   assign kill_grant = |(req_kill_i & grant_onehot);
   assign cnt_done   = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   // A kill in the same cycle as the memory ack suppresses the ack.
   assign ack_fire = (state_q == BUSY) && mem_ack_i && !kill_grant;

   assign req_ack_o    = ack_fire ? grant_onehot : '0;
   assign req_r_data_o = ack_fire ? mem_r_data_i : '0;

   // ---------------------------------------------------------------------
   // Control FSM with registered memory-side outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         ptr_q        <= '0;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_w_en_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_w_data_q <= '0;
         tout_q       <= '0;
      end else begin
         tout_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q      <= pick_idx;
                  ptr_q        <= ptr_d;
                  cnt_q        <= '0;
                  mem_req_q    <= 1'b1;
                  mem_w_en_q   <= req_w_en_i[pick_idx];
                  mem_addr_q   <= addr_slice[pick_idx];
                  mem_w_data_q <= wdata_slice[pick_idx];
                  state_q      <= BUSY;
               end
            end

            BUSY: begin
               if (kill_grant) begin
                  mem_req_q  <= 1'b0;
                  mem_w_en_q <= 1'b0;
                  cnt_q      <= '0;
                  // Response already here: nothing left to drain.
                  state_q    <= mem_ack_i ? IDLE : DRAIN;
               end else if (mem_ack_i) begin
                  mem_req_q  <= 1'b0;
                  mem_w_en_q <= 1'b0;
                  state_q    <= IDLE;
               end else if (cnt_done) begin
                  tout_q     <= grant_onehot;
                  mem_req_q  <= 1'b0;
                  mem_w_en_q <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            DRAIN: begin
               // The killed response is swallowed silently; a lost response
               // is bounded by the same timeout but reports nothing.
               if (mem_ack_i || cnt_done) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o    = mem_req_q;
   assign mem_w_en_o   = mem_w_en_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_w_data_o = mem_w_data_q;
   assign req_tout_o   = tout_q;

endmodule : mem_arbiter_nport
`default_nettype wire

// File: tb/tb_mem_arbiter_nport.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter_nport
// Purpose : Directed self-checking bench for mem_arbiter_nport.
//           Two instances share all inputs: dut_rr (round-robin) and
//           dut_fx (fixed priority). Both see identical transaction timing,
//           only the winning channel differs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_nport;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int TO = 48;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req, kill, wen;
   logic [N*AW-1:0] addr_bus;
   logic [N*DW-1:0] wdata_bus;
   logic            mem_ack;
   logic [DW-1:0]   mem_rdata;

   logic [N-1:0]  ack_rr, tout_rr, ack_fx, tout_fx;
   logic [DW-1:0] rdata_rr, rdata_fx, mwdata_rr, mwdata_fx;
   logic          mreq_rr, mwen_rr, mreq_fx, mwen_fx;
   logic [AW-1:0] maddr_rr, maddr_fx;

   int n_tot = 0;
   int n_bad = 0;

   mem_arbiter_nport #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TO)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .req_i(req), .req_kill_i(kill), .req_w_en_i(wen),
      .req_addr_i(addr_bus), .req_w_data_i(wdata_bus),
      .req_ack_o(ack_rr), .req_r_data_o(rdata_rr), .req_tout_o(tout_rr),
      .mem_req_o(mreq_rr), .mem_w_en_o(mwen_rr), .mem_addr_o(maddr_rr),
      .mem_w_data_o(mwdata_rr), .mem_ack_i(mem_ack), .mem_r_data_i(mem_rdata)
   );

   mem_arbiter_nport #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TO)) dut_fx (
      .clk(clk), .rst_n(rst_n),
      .req_i(req), .req_kill_i(kill), .req_w_en_i(wen),
      .req_addr_i(addr_bus), .req_w_data_i(wdata_bus),
      .req_ack_o(ack_fx), .req_r_data_o(rdata_fx), .req_tout_o(tout_fx),
      .mem_req_o(mreq_fx), .mem_w_en_o(mwen_fx), .mem_addr_o(maddr_fx),
      .mem_w_data_o(mwdata_fx), .mem_ack_i(mem_ack), .mem_r_data_i(mem_rdata)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] a_of(input int k);
      return 32'h1000_0000 + AW'(k * 256);
   endfunction

   // Inputs change 1 ns after the rising edge; checks follow after settle().
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      kill      = '0;
      wen       = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      for (int k = 0; k < N; k++) begin
         addr_bus[k*AW +: AW]  = a_of(k);
         wdata_bus[k*DW +: DW] = {4{32'hC000_0000 + 32'(k)}};
      end
      step();
      step();
      rst_n = 1'b1;
      settle();
   endtask

   task automatic wait_grant(input string tag);
      for (int i = 0; i < 8; i++) begin
         if (mreq_rr) break;
         step();
      end
      settle();
      check({tag, "_req"}, DW'(mreq_rr), 1);
   endtask

   // Memory acks three cycles after mem_req_o rose; req becomes req_after
   // in the ack cycle (ignored by a busy arbiter).
   task automatic ack_pulse(input string tag, input logic [DW-1:0] data,
                            input logic [N-1:0] exp_rr, input logic [N-1:0] exp_fx,
                            input logic [N-1:0] req_after);
      step();
      step();
      mem_ack   = 1'b1;
      mem_rdata = data;
      req       = req_after;
      settle();
      check({tag, "_ack_rr"}, DW'(ack_rr), DW'(exp_rr));
      check({tag, "_ack_fx"}, DW'(ack_fx), DW'(exp_fx));
      check({tag, "_rdata"}, rdata_rr, data);
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      settle();
      check({tag, "_after"}, DW'({ack_rr, mreq_rr}), 0);
   endtask

   initial begin
      int early;

      // ---------------- reset state ----------------
      do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_ctl", DW'({mreq_rr, mwen_rr, ack_rr, tout_rr}), 0);
      check("rst_addr", DW'(maddr_rr), 0);
      check("rst_wdata", mwdata_rr, 0);
      check("rst_rdata", rdata_rr, 0);

      // ---------------- round-robin sweep, all requesting ----------------
      do_reset();
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_grant($sformatf("rr%0d", t));
         check($sformatf("rr%0d_addr", t), DW'(maddr_rr), DW'(a_of(t % 4)));
         ack_pulse($sformatf("rr%0d", t), {4{32'hD000_0000 + 32'(t)}},
                   4'(1 << (t % 4)), 4'b0001, 4'b1111);
      end
      req = '0;

      // ---------------- fixed priority, 0110 ----------------
      do_reset();
      req = 4'b0110;
      wait_grant("fx0");
      check("fx0_addr", DW'(maddr_fx), DW'(a_of(1)));
      ack_pulse("fx0", 128'h11, 4'b0010, 4'b0010, 4'b0110);
      wait_grant("fx1");
      check("fx1_addr", DW'(maddr_fx), DW'(a_of(1)));
      ack_pulse("fx1", 128'h22, 4'b0100, 4'b0010, 4'b0100);
      wait_grant("fx2");
      check("fx2_addr", DW'(maddr_fx), DW'(a_of(2)));
      ack_pulse("fx2", 128'h33, 4'b0100, 4'b0100, 4'b0000);

      // ---------------- write from ch2 ----------------
      do_reset();
      addr_bus[2*AW +: AW]  = 32'h8000_0040;
      wdata_bus[2*DW +: DW] = {16{8'hA5}};
      wen = 4'b0100;
      req = 4'b0100;
      settle();
      check("wr_t0_req", DW'(mreq_rr), 0);
      step();
      settle();
      check("wr_t1_ctl", DW'({mreq_rr, mwen_rr}), DW'(2'b11));
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wr_addr%0d", i), DW'(maddr_rr), DW'(32'h8000_0040));
         check($sformatf("wr_data%0d", i), mwdata_rr, {16{8'hA5}});
         step();
      end
      mem_ack = 1'b1;
      settle();
      check("wr_ack", DW'(ack_rr), DW'(4'b0100));
      step();
      mem_ack = 1'b0;
      req     = '0;
      wen     = '0;
      settle();
      check("wr_done", DW'(mreq_rr), 0);

      // ---------------- kill on ch0, then late ack ----------------
      do_reset();
      req = 4'b0001;
      step();
      settle();
      check("kl_grant", DW'(mreq_rr), 1);
      step();
      kill = 4'b0001;
      req  = '0;
      settle();
      check("kl_noack", DW'(ack_rr), 0);
      step();
      kill = '0;
      req  = 4'b0010;
      settle();
      check("kl_drain", DW'(mreq_rr), 0);
      early = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (mreq_rr || mreq_fx) early++;
      end
      check("kl_hold", DW'(early), 0);
      mem_ack = 1'b1;
      settle();
      check("kl_late_ack", DW'({ack_rr, ack_fx}), 0);
      step();
      mem_ack = 1'b0;
      settle();
      check("kl_idle", DW'(mreq_rr), 0);
      step();
      settle();
      check("kl_next", DW'({mreq_rr, maddr_rr}), DW'({1'b1, a_of(1)}));
      ack_pulse("kl_ch1", 128'h44, 4'b0010, 4'b0010, 4'b0001);

      // kill and mem_ack together: no ack, straight to IDLE
      step();
      settle();
      check("ka_grant", DW'({mreq_rr, maddr_rr}), DW'({1'b1, a_of(0)}));
      step();
      kill    = 4'b0001;
      mem_ack = 1'b1;
      req     = '0;
      settle();
      check("ka_noack", DW'({ack_rr, ack_fx, rdata_rr}), 0);
      step();
      kill    = '0;
      mem_ack = 1'b0;
      req     = 4'b0010;
      settle();
      check("ka_idle", DW'(mreq_rr), 0);
      step();
      settle();
      check("ka_direct", DW'({mreq_rr, maddr_rr}), DW'({1'b1, a_of(1)}));
      ack_pulse("ka_ch1", 128'h55, 4'b0010, 4'b0010, 4'b0000);

      // ---------------- timeout ----------------
      do_reset();
      req = 4'b0001;
      step();
      settle();
      check("to_grant", DW'(mreq_rr), 1);
      early = 0;
      for (int i = 1; i < TO; i++) begin
         step();
         if (tout_rr != '0 || !mreq_rr) early++;
      end
      check("to_early", DW'(early), 0);
      step();
      req = 4'b0010;
      settle();
      check("to_pulse_rr", DW'(tout_rr), DW'(4'b0001));
      check("to_pulse_fx", DW'(tout_fx), DW'(4'b0001));
      check("to_clear", DW'({mreq_rr, ack_rr}), 0);
      step();
      settle();
      check("to_one_cycle", DW'(tout_rr), 0);
      check("to_next", DW'({mreq_rr, maddr_rr}), DW'({1'b1, a_of(1)}));
      ack_pulse("to_ch1", 128'h66, 4'b0010, 4'b0010, 4'b0000);

      // ---------------- async reset mid-transaction ----------------
      do_reset();
      addr_bus[2*AW +: AW]  = 32'h8000_0040;
      wdata_bus[2*DW +: DW] = {16{8'hA5}};
      wen = 4'b0100;
      req = 4'b0100;
      step();
      settle();
      check("ar_busy", DW'({mreq_rr, mwen_rr}), DW'(2'b11));
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ctl", DW'({mreq_rr, mwen_rr, ack_rr, tout_rr}), 0);
      check("ar_addr", DW'(maddr_rr), 0);
      check("ar_wdata", mwdata_rr, 0);
      req = '0;
      wen = '0;
      step();
      rst_n = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 128'hDEAD;
      settle();
      check("ar_late_ack", DW'(ack_rr), 0);
      check("ar_late_rdata", rdata_rr, 0);
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      req       = 4'b1000;
      settle();
      check("ar_idle", DW'(mreq_rr), 0);
      step();
      settle();
      check("ar_fresh", DW'({mreq_rr, mwen_rr, maddr_rr}), DW'({2'b10, a_of(3)}));
      ack_pulse("ar_ch3", 128'h77, 4'b1000, 4'b1000, 4'b0000);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_tot, n_bad);
      $fatal(1);
   end

endmodule : tb_mem_arbiter_nport
`default_nettype wire
